round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/game_pkg.sv | 43 ++++
 rtl/round_timer.sv | 42 ++++
 rtl/round_controller.sv | 152 +++++++++++++++
 tb/tb_round_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and helpers.
// Holds rating/game-state widths, the game_state enum used by game_status,
// the round FSM state encoding, and the round duration calculation.
package game_pkg;

    localparam int unsigned RATING_WIDTH     = 8;
    localparam int unsigned GAME_STATE_WIDTH = 2;

    typedef enum logic [GAME_STATE_WIDTH-1:0] {
        GameIdle,
        GamePlaying,
        GamePaused,
        GameOver
    } game_state_e;

    // Encoding is visible on o_phase, so keep values fixed.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGen     = 3'd1,
        StPreview = 3'd2,
        StRun     = 3'd3,
        StDone    = 3'd4,
        StOver    = 3'd5
    } round_state_e;

    // max(min_ticks, base - rating*step), evaluated in 32 bits so neither the
    // product nor the subtraction can wrap.
    function automatic logic [7:0] round_duration(
        input logic [RATING_WIDTH-1:0] rating,
        input int unsigned             base,
        input int unsigned             min_ticks,
        input int unsigned             step
    );
        logic [31:0] prod;
        logic [31:0] diff;
        prod = 32'(rating) * 32'(step);
        if (prod >= base) diff = 32'd0;
        else              diff = base - prod;
        if (diff < min_ticks) diff = min_ticks;
        return 8'(diff);
    endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter, decremented by tick strobes while enabled and unpaused.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         load count with load_value (wins over a decrement)
//   load_value   value to load
//   enable       counting allowed (owner state active)
//   tick, pause  time-base strobe and pause level
//   count        current count
//   zero         count is 0
//   expire       this cycle's tick takes count from 1 to 0
module round_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             tick,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             expire
);

    logic step;

    assign zero   = (count == '0);
    assign step   = enable && tick && !pause && !zero;
    assign expire = step && (count == WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (step) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/round_controller.sv
// Round sequencer: level generation, zone preview, timed run, result strobe.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_start             start request (IDLE only)
//   i_tick              time-base strobe
//   i_pause_game        pause level; freezes counters and the DONE strobe
//   i_current_rating    rating, sampled when the level becomes ready
//   i_level_ready       level generator done (GEN only)
//   i_player_in_zone    player in safe zone, decides a timeout win
//   i_player_hit        player killed (RUN only)
//   o_level_gen_start   one-cycle pulse on entering GEN
//   o_round_ended       one-cycle round-end strobe
//   o_is_win            round result, held until the next DONE
//   o_time_left         remaining round ticks
//   o_phase             current FSM state
module round_controller
    import game_pkg::*;
#(
    parameter int unsigned BASE_TICKS    = 200,
    parameter int unsigned MIN_TICKS     = 40,
    parameter int unsigned STEP_TICKS    = 8,
    parameter int unsigned PREVIEW_TICKS = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_tick,
    input  logic                    i_pause_game,
    input  logic [RATING_WIDTH-1:0] i_current_rating,
    input  logic                    i_level_ready,
    input  logic                    i_player_in_zone,
    input  logic                    i_player_hit,
    output logic                    o_level_gen_start,
    output logic                    o_round_ended,
    output logic                    o_is_win,
    output logic [7:0]              o_time_left,
    output logic [2:0]              o_phase
);

    round_state_e state_q, state_d;
    logic         gen_start_q, gen_start_d;
    logic         is_win_q, is_win_d;
    logic         hit_pend_q, hit_pend_d;
    logic         load_timers;
    logic         hit_now;
    logic         round_ended;
    logic [7:0]   duration;
    logic [7:0]   pv_count, rt_count;
    logic         pv_zero, pv_expire, rt_zero, rt_expire;

    assign duration = round_duration(i_current_rating, BASE_TICKS, MIN_TICKS, STEP_TICKS);

    // A hit seen while paused is remembered and acted on once unpaused.
    assign hit_now = (state_q == StRun) && !i_pause_game && (i_player_hit || hit_pend_q);

    round_timer #(.WIDTH(8)) u_preview_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load_timers),
        .load_value (8'(PREVIEW_TICKS)),
        .enable     (state_q == StPreview),
        .tick       (i_tick),
        .pause      (i_pause_game),
        .count      (pv_count),
        .zero       (pv_zero),
        .expire     (pv_expire)
    );

    round_timer #(.WIDTH(8)) u_round_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load_timers),
        .load_value (duration),
        .enable     ((state_q == StRun) && !hit_now),
        .tick       (i_tick),
        .pause      (i_pause_game),
        .count      (rt_count),
        .zero       (rt_zero),
        .expire     (rt_expire)
    );

    always_comb begin
        state_d     = state_q;
        is_win_d    = is_win_q;
        hit_pend_d  = hit_pend_q;
        load_timers = 1'b0;
        round_ended = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StGen;
            end
            StGen: begin
                if (i_level_ready) begin
                    state_d     = StPreview;
                    load_timers = 1'b1;
                end
            end
            StPreview: begin
                // pv_zero covers a zero-length preview
                if (pv_zero || pv_expire) state_d = StRun;
            end
            StRun: begin
                if (hit_now) begin
                    state_d    = StDone;
                    is_win_d   = 1'b0;
                    hit_pend_d = 1'b0;
                end else if (rt_expire || (rt_zero && !i_pause_game)) begin
                    state_d    = StDone;
                    is_win_d   = i_player_in_zone;
                    hit_pend_d = 1'b0;
                end else if (i_player_hit) begin
                    // only reachable while paused
                    hit_pend_d = 1'b1;
                end
            end
            StDone: begin
                if (!i_pause_game) begin
                    round_ended = 1'b1;
                    state_d     = is_win_q ? StGen : StOver;
                end
            end
            StOver: begin
                state_d = StOver;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        gen_start_d = (state_d == StGen) && (state_q != StGen);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gen_start_q <= 1'b0;
            is_win_q    <= 1'b0;
            hit_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_start_q <= gen_start_d;
            is_win_q    <= is_win_d;
            hit_pend_q  <= hit_pend_d;
        end
    end

    assign o_level_gen_start = gen_start_q;
    assign o_round_ended     = round_ended;
    assign o_is_win          = is_win_q;
    assign o_time_left       = rt_count;
    assign o_phase           = state_q;

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

    localparam logic [2:0] PH_IDLE = 3'd0, PH_GEN = 3'd1, PH_PREVIEW = 3'd2,
                           PH_RUN = 3'd3, PH_DONE = 3'd4, PH_OVER = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 0, i_tick = 0, i_pause_game = 0;
    logic [7:0] i_current_rating = 0;
    logic       i_level_ready = 0, i_player_in_zone = 0, i_player_hit = 0;
    logic       o_level_gen_start, o_round_ended, o_is_win;
    logic [7:0] o_time_left;
    logic [2:0] o_phase;

    int passed = 0;
    int total = 0;
    int ended_cnt = 0;
    int snap;

    round_controller dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (i_start),
        .i_tick            (i_tick),
        .i_pause_game      (i_pause_game),
        .i_current_rating  (i_current_rating),
        .i_level_ready     (i_level_ready),
        .i_player_in_zone  (i_player_in_zone),
        .i_player_hit      (i_player_hit),
        .o_level_gen_start (o_level_gen_start),
        .o_round_ended     (o_round_ended),
        .o_is_win          (o_is_win),
        .o_time_left       (o_time_left),
        .o_phase           (o_phase)
    );

    always #5 clk = ~clk;

    // Counts cycles with the round-end strobe high, sampled mid-cycle.
    always @(negedge clk) if (o_round_ended === 1'b1) ended_cnt++;

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    // Each tick: one idle cycle, then a one-cycle strobe; returns just after the tick edge.
    task automatic tick(input int n);
        repeat (n) begin
            cycle();
            i_tick = 1'b1;
            cycle();
            i_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_start = 0; i_tick = 0; i_pause_game = 0; i_level_ready = 0;
        i_player_hit = 0; i_player_in_zone = 0; i_current_rating = 0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
    endtask

    // Leaves the DUT in PREVIEW with timers loaded for the given rating.
    task automatic begin_round(input logic [7:0] rating);
        i_start = 1'b1;
        cycle();
        i_start = 1'b0;
        cycle();
        i_current_rating = rating;
        i_level_ready = 1'b1;
        cycle();
        i_level_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (o_phase !== PH_IDLE) $display("FAIL reset_phase: got %0d want %0d", o_phase, PH_IDLE); else passed++;
        total++; if (o_time_left !== 8'd0) $display("FAIL reset_time: got %0d want 0", o_time_left); else passed++;
        total++; if ({o_level_gen_start, o_round_ended, o_is_win} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {o_level_gen_start, o_round_ended, o_is_win}); else passed++;
        // level_ready in IDLE must be ignored
        i_level_ready = 1'b1; cycle(); i_level_ready = 1'b0;
        total++; if (o_phase !== PH_IDLE) $display("FAIL idle_ignore_ready: got %0d want %0d", o_phase, PH_IDLE); else passed++;
    endtask

    task automatic test_full_round();
        do_reset();
        i_player_in_zone = 1'b1;
        i_start = 1'b1; cycle(); i_start = 1'b0;
        total++; if (o_phase !== PH_GEN) $display("FAIL gen_phase: got %0d want %0d", o_phase, PH_GEN); else passed++;
        total++; if (o_level_gen_start !== 1'b1) $display("FAIL gen_pulse: got %b want 1", o_level_gen_start); else passed++;
        cycle();
        total++; if (o_level_gen_start !== 1'b0) $display("FAIL gen_pulse_len: got %b want 0", o_level_gen_start); else passed++;
        i_current_rating = 8'd0; i_level_ready = 1'b1; cycle(); i_level_ready = 1'b0;
        total++; if (o_phase !== PH_PREVIEW) $display("FAIL preview_phase: got %0d want %0d", o_phase, PH_PREVIEW); else passed++;
        total++; if (o_time_left !== 8'd200) $display("FAIL load_r0: got %0d want 200", o_time_left); else passed++;
        tick(29);
        total++; if (o_phase !== PH_PREVIEW) $display("FAIL preview_29: got %0d want %0d", o_phase, PH_PREVIEW); else passed++;
        tick(1);
        total++; if (o_phase !== PH_RUN) $display("FAIL run_after_30: got %0d want %0d", o_phase, PH_RUN); else passed++;
        total++; if (o_time_left !== 8'd200) $display("FAIL run_start_time: got %0d want 200", o_time_left); else passed++;
        snap = ended_cnt;
        tick(199);
        total++; if (o_time_left !== 8'd1) $display("FAIL time_229: got %0d want 1", o_time_left); else passed++;
        total++; if (ended_cnt - snap !== 0) $display("FAIL early_end: got %0d want 0", ended_cnt - snap); else passed++;
        tick(1);
        total++; if (o_round_ended !== 1'b1) $display("FAIL end_230: got %b want 1", o_round_ended); else passed++;
        total++; if (o_is_win !== 1'b1) $display("FAIL win_230: got %b want 1", o_is_win); else passed++;
        cycle();
        total++; if (o_phase !== PH_GEN) $display("FAIL win_to_gen: got %0d want %0d", o_phase, PH_GEN); else passed++;
        total++; if (o_level_gen_start !== 1'b1) $display("FAIL win_gen_pulse: got %b want 1", o_level_gen_start); else passed++;
        total++; if (o_is_win !== 1'b1) $display("FAIL win_held: got %b want 1", o_is_win); else passed++;
        cycle(); cycle();
        total++; if (ended_cnt - snap !== 1) $display("FAIL end_pulse_count: got %0d want 1", ended_cnt - snap); else passed++;
        // still in GEN: rating 30 saturates at MIN_TICKS
        i_current_rating = 8'd30; i_level_ready = 1'b1; cycle(); i_level_ready = 1'b0;
        total++; if (o_time_left !== 8'd40) $display("FAIL load_r30: got %0d want 40", o_time_left); else passed++;
    endtask

    task automatic test_pause_run();
        do_reset();
        i_player_in_zone = 1'b1;
        begin_round(8'd10);
        total++; if (o_time_left !== 8'd120) $display("FAIL load_r10: got %0d want 120", o_time_left); else passed++;
        tick(30 + 115);
        total++; if (o_time_left !== 8'd5) $display("FAIL pre_pause: got %0d want 5", o_time_left); else passed++;
        i_pause_game = 1'b1;
        tick(50);
        total++; if (o_time_left !== 8'd5) $display("FAIL paused_time: got %0d want 5", o_time_left); else passed++;
        total++; if (o_phase !== PH_RUN) $display("FAIL paused_phase: got %0d want %0d", o_phase, PH_RUN); else passed++;
        i_pause_game = 1'b0;
        snap = ended_cnt;
        tick(4);
        total++; if (o_phase !== PH_RUN || o_time_left !== 8'd1)
            $display("FAIL resume_4: got phase %0d time %0d want phase 3 time 1", o_phase, o_time_left); else passed++;
        tick(1);
        total++; if (o_round_ended !== 1'b1) $display("FAIL resume_end: got %b want 1", o_round_ended); else passed++;
        cycle();
        total++; if (ended_cnt - snap !== 1) $display("FAIL resume_pulses: got %0d want 1", ended_cnt - snap); else passed++;
    endtask

    task automatic test_pending_hit();
        do_reset();
        i_player_in_zone = 1'b1;
        begin_round(8'd0);
        tick(30);
        i_pause_game = 1'b1;
        i_player_hit = 1'b1; cycle(); i_player_hit = 1'b0;
        cycle(); cycle();
        total++; if (o_phase !== PH_RUN) $display("FAIL hit_paused_phase: got %0d want %0d", o_phase, PH_RUN); else passed++;
        i_pause_game = 1'b0;
        cycle();
        total++; if (o_phase !== PH_DONE || o_round_ended !== 1'b1 || o_is_win !== 1'b0)
            $display("FAIL pending_hit: got phase %0d end %b win %b want phase 4 end 1 win 0",
                     o_phase, o_round_ended, o_is_win); else passed++;
    endtask

    task automatic test_hit_vs_timeout();
        do_reset();
        i_player_in_zone = 1'b1;
        begin_round(8'd30);
        tick(30 + 39);
        total++; if (o_time_left !== 8'd1) $display("FAIL hit_setup: got %0d want 1", o_time_left); else passed++;
        cycle();
        i_tick = 1'b1; i_player_hit = 1'b1;
        cycle();
        i_tick = 1'b0; i_player_hit = 1'b0;
        total++; if (o_round_ended !== 1'b1 || o_is_win !== 1'b0)
            $display("FAIL hit_priority: got end %b win %b want end 1 win 0", o_round_ended, o_is_win); else passed++;
        cycle();
        total++; if (o_phase !== PH_OVER) $display("FAIL over_phase: got %0d want %0d", o_phase, PH_OVER); else passed++;
        i_start = 1'b1; cycle(); i_start = 1'b0;
        cycle();
        total++; if (o_phase !== PH_OVER || o_level_gen_start !== 1'b0)
            $display("FAIL over_ignore_start: got phase %0d gen %b want phase 5 gen 0",
                     o_phase, o_level_gen_start); else passed++;
    endtask

    task automatic test_pause_done();
        do_reset();
        i_player_in_zone = 1'b1;
        begin_round(8'd30);
        tick(30 + 40);
        i_pause_game = 1'b1;
        snap = ended_cnt;
        #1;
        total++; if (o_phase !== PH_DONE || o_round_ended !== 1'b0)
            $display("FAIL done_paused: got phase %0d end %b want phase 4 end 0", o_phase, o_round_ended); else passed++;
        cycle(); cycle(); cycle();
        total++; if (o_phase !== PH_DONE || ended_cnt - snap !== 0)
            $display("FAIL done_hold: got phase %0d pulses %0d want phase 4 pulses 0", o_phase, ended_cnt - snap); else passed++;
        i_pause_game = 1'b0;
        #1;
        total++; if (o_round_ended !== 1'b1) $display("FAIL done_unpause: got %b want 1", o_round_ended); else passed++;
        cycle(); cycle();
        total++; if (ended_cnt - snap !== 1 || o_phase !== PH_GEN)
            $display("FAIL done_once: got pulses %0d phase %0d want pulses 1 phase 1", ended_cnt - snap, o_phase); else passed++;
    endtask

    task automatic test_reset_mid();
        // reset during DONE kills the strobe in the same cycle
        do_reset();
        i_player_in_zone = 1'b1;
        begin_round(8'd30);
        tick(30 + 40);
        total++; if (o_round_ended !== 1'b1) $display("FAIL rst_done_setup: got %b want 1", o_round_ended); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (o_round_ended !== 1'b0 || o_is_win !== 1'b0 || o_phase !== PH_IDLE)
            $display("FAIL rst_in_done: got end %b win %b phase %0d want 0 0 0", o_round_ended, o_is_win, o_phase); else passed++;
        cycle(); rst = 1'b0; cycle();
        // reset mid-RUN
        begin_round(8'd0);
        tick(40);
        total++; if (o_phase !== PH_RUN || o_time_left !== 8'd190)
            $display("FAIL rst_run_setup: got phase %0d time %0d want phase 3 time 190", o_phase, o_time_left); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (o_phase !== PH_IDLE || o_time_left !== 8'd0 || o_level_gen_start !== 1'b0 || o_round_ended !== 1'b0)
            $display("FAIL rst_in_run: got phase %0d time %0d gen %b end %b want 0 0 0 0",
                     o_phase, o_time_left, o_level_gen_start, o_round_ended); else passed++;
        cycle(); rst = 1'b0; cycle();
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_pause_run();
        test_pending_hit();
        test_hit_vs_timeout();
        test_pause_done();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
